spwm_carrier_gen: RTL and testbench
===================================

Name: spwm_carrier_gen

Overview:
Parametrised SPWM carrier generator: produces a prescaled ramp (saw-down, saw-up or triangle) from 0 to a runtime-programmable top value, for the comparator stage that builds the SPWM gate signals. Adds mode select, glitch-free top/mode reload at period boundaries, a graceful stop that finishes the current period, and boundary strobes for downstream synchronisation.

Parameters:
WIDTH, 15, carrier and top width in bits
PRESCALE, 3, clocks per carrier step (>=1)
TOP_DEFAULT, 15358, top value after reset until first load

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  run request; sampled every clock
mode  input  2  00 saw-down, 01 saw-up, 10 triangle, 11 reserved (treated as 00)
top  input  WIDTH  ramp peak value, shadow-loaded at period start
carrier  output  WIDTH  current ramp value (registered)
step  output  1  one-clock pulse on every carrier update
period_start  output  1  one-clock pulse when a new period begins
peak  output  1  one-clock pulse when carrier takes value top_q
valley  output  1  one-clock pulse when carrier takes value 0
dir  output  1  1 = rising, 0 = falling (triangle; fixed per saw mode)
busy  output  1  1 while in RUN

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: carrier=0, step=peak=valley=period_start=0, dir=0, busy=0, prescaler=0, top_q=TOP_DEFAULT, mode_q=00, state IDLE. rst mid-run: next clock holds reset values, no further strobes.
- States: IDLE, RUN.
- IDLE & en=1 at edge N: load top_q<=top, mode_q<=mode, prescaler<=0. At N+1: busy=1, period_start=1, carrier=initial value (saw-down: top_q; saw-up and triangle: 0), peak/valley pulse if initial value equals top_q/0.
- RUN: prescaler counts 0..PRESCALE-1. When it reaches PRESCALE-1 it returns to 0 and the carrier advances with step=1. Carrier changes only on those cycles, so each value is held exactly PRESCALE clocks.
- Saw-down: top_q, top_q-1 ... 0, then wrap to top_q. Saw-up: 0 ... top_q, then wrap to 0. Period = top_q+1 steps. The wrap step is a period boundary.
- Triangle: 0 up to top_q (dir=1), then down to 0 (dir=0). Period = 2*top_q steps. Boundary is the step that leaves 0 going up again. The top_q value is emitted once per period, not repeated; 0 is also emitted once.
- Period boundary step: new top/mode shadow-loaded, period_start=1 with the same update. Mid-period changes of top or mode have no effect.
- Graceful stop: if en=0 at the boundary step, the wrap is not taken. Carrier holds its final value (saw-down 0, saw-up top_q, triangle 0), state goes to IDLE, busy=0, no period_start. If en=1 at that edge, the next period starts without a gap.
- top=0: carrier stays 0. Every step is a boundary with period_start=1. In triangle mode both peak and valley pulse every step.
- No arithmetic overflow: values stay in 0..top_q. Carrier never underflows below 0 or exceeds top_q.
- Strobes are registered and coincide with the cycle where carrier shows the new value.
- dir: saw-down 0, saw-up 1, triangle as above. In IDLE, dir holds its last value.

Test Plan:
- Reset: assert rst 2 clocks with en=1 -> carrier=0, busy=0, all strobes 0. After release, busy=1 one clock later.
- Saw-down, top=5, PRESCALE=3, en held -> carrier 5,4,3,2,1,0,5..., each held 3 clocks. period_start with every 5, valley with every 0, 18 clocks per period.
- Triangle, top=3 -> carrier 0,1,2,3,2,1,0,1... Peak once per period at 3, valley at 0, dir toggles at 3 and 0, period=18 clocks.
- Graceful stop, saw-up, top=5: drop en when carrier=2 -> continues 3,4,5, then busy=0 and carrier holds 5. Re-raise en -> carrier 0 with period_start one clock later.
- Shadow reload: saw-down top=5, change top to 2 when carrier=3 -> 2,1,0 still from the old period, then 2,1,0,2... Same check for mode 00->10 mid-period, which takes effect only at the wrap.
- Edge cases: top=0 in triangle -> carrier 0, peak, valley and period_start every 3 clocks. Assert rst when carrier=4 -> next clock carrier=0, busy=0.

Source files
------------

// File: rtl/spwm_carrier_gen.sv
// Prescaled carrier ramp (saw-down, saw-up, triangle) for an SPWM comparator stage.
// Top and mode are shadow-loaded only at period boundaries; dropping en stops cleanly at the next boundary.
module spwm_carrier_gen #(
    parameter int WIDTH       = 15,
    parameter int PRESCALE    = 3,
    parameter int TOP_DEFAULT = 15358
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] carrier,
    output logic             step,
    output logic             period_start,
    output logic             peak,
    output logic             valley,
    output logic             dir,
    output logic             busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PONE  = PW'(1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        M_DOWN = 2'b00,
        M_UP   = 2'b01,
        M_TRI  = 2'b10,
        M_RSV  = 2'b11
    } mode_t;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d, mode_in;
    logic [WIDTH-1:0] top_q, top_d;
    logic [WIDTH-1:0] carrier_q, carrier_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             step_q, step_d;
    logic             ps_q, ps_d;
    logic             peak_q, peak_d;
    logic             valley_q, valley_d;

    logic [WIDTH-1:0] start_val;
    logic             start_dir;
    logic [WIDTH-1:0] nxt;
    logic             dir_nxt;
    logic             upd;
    logic             at_boundary;

    // Reserved mode code behaves as saw-down.
    always_comb begin
        mode_in = M_DOWN;
        unique case (mode)
            2'b01:   mode_in = M_UP;
            2'b10:   mode_in = M_TRI;
            default: mode_in = M_DOWN;
        endcase
    end

    // First value of a new period. A triangle continuing from 0 skips straight to 1 so 0 is not shown twice.
    always_comb begin
        start_val = '0;
        start_dir = 1'b0;
        unique case (mode_in)
            M_UP: begin
                start_val = '0;
                start_dir = 1'b1;
            end
            M_TRI: begin
                start_val = (state_q == RUN && carrier_q == '0 && top != '0) ? ONE : '0;
                start_dir = (start_val != top);
            end
            default: begin
                start_val = top;
                start_dir = 1'b0;
            end
        endcase
    end

    // Period boundary: saw wraps, or a triangle about to leave 0 after descending.
    always_comb begin
        at_boundary = 1'b0;
        unique case (mode_q)
            M_UP:    at_boundary = (carrier_q == top_q);
            M_TRI:   at_boundary = !dir_q && (carrier_q == '0);
            default: at_boundary = (carrier_q == '0);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        top_d     = top_q;
        carrier_d = carrier_q;
        presc_d   = presc_q;
        dir_d     = dir_q;
        busy_d    = busy_q;
        step_d    = 1'b0;
        ps_d      = 1'b0;
        peak_d    = 1'b0;
        valley_d  = 1'b0;
        nxt       = carrier_q;
        dir_nxt   = dir_q;
        upd       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    presc_d = '0;
                    top_d   = top;
                    mode_d  = mode_in;
                    ps_d    = 1'b1;
                    nxt     = start_val;
                    dir_nxt = start_dir;
                    upd     = 1'b1;
                end
            end
            RUN: begin
                if (presc_q == PLAST) begin
                    presc_d = '0;
                    if (at_boundary) begin
                        if (!en) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            top_d   = top;
                            mode_d  = mode_in;
                            ps_d    = 1'b1;
                            step_d  = 1'b1;
                            nxt     = start_val;
                            dir_nxt = start_dir;
                            upd     = 1'b1;
                        end
                    end else begin
                        step_d = 1'b1;
                        upd    = 1'b1;
                        unique case (mode_q)
                            M_UP: begin
                                nxt     = carrier_q + ONE;
                                dir_nxt = 1'b1;
                            end
                            M_TRI: begin
                                if (dir_q) begin
                                    nxt     = carrier_q + ONE;
                                    dir_nxt = (nxt != top_q);
                                end else begin
                                    nxt     = carrier_q - ONE;
                                    dir_nxt = 1'b0;
                                end
                            end
                            default: begin
                                nxt     = carrier_q - ONE;
                                dir_nxt = 1'b0;
                            end
                        endcase
                    end
                end else begin
                    presc_d = presc_q + PONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (upd) begin
            carrier_d = nxt;
            dir_d     = dir_nxt;
            peak_d    = (nxt == top_d);
            valley_d  = (nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= M_DOWN;
            top_q     <= WIDTH'(TOP_DEFAULT);
            carrier_q <= '0;
            presc_q   <= '0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= 1'b0;
            ps_q      <= 1'b0;
            peak_q    <= 1'b0;
            valley_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            top_q     <= top_d;
            carrier_q <= carrier_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            step_q    <= step_d;
            ps_q      <= ps_d;
            peak_q    <= peak_d;
            valley_q  <= valley_d;
        end
    end

    assign carrier      = carrier_q;
    assign step         = step_q;
    assign period_start = ps_q;
    assign peak         = peak_q;
    assign valley       = valley_q;
    assign dir          = dir_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_spwm_carrier_gen.sv
// Bench for spwm_carrier_gen: directed scenarios then random traffic, checked every clock
// against a period-list model (each period is expanded into its sequence of shown values).
module tb_spwm_carrier_gen;

    localparam int W        = 15;
    localparam int PRESCALE = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] top;
    logic [W-1:0] carrier;
    logic         step;
    logic         period_start;
    logic         peak;
    logic         valley;
    logic         dir;
    logic         busy;

    always #5 clk = ~clk;

    spwm_carrier_gen #(
        .WIDTH      (W),
        .PRESCALE   (PRESCALE),
        .TOP_DEFAULT(15358)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .top         (top),
        .carrier     (carrier),
        .step        (step),
        .period_start(period_start),
        .peak        (peak),
        .valley      (valley),
        .dir         (dir),
        .busy        (busy)
    );

    typedef struct packed {
        logic [W-1:0] val;
        logic         dir;
        logic         ps;
    } ent_t;

    ent_t per_q[$];
    int   m_top;
    int   m_cnt;
    logic [W-1:0] m_carrier;
    logic m_dir, m_busy, m_step, m_ps, m_peak, m_valley;

    int n_vec = 0;
    int n_checks = 0;
    int n_err = 0;

    function automatic void push(input int v, input logic d);
        ent_t e;
        e.val = W'(v);
        e.dir = d;
        e.ps  = 1'b0;
        per_q.push_back(e);
    endfunction

    // Expand one whole period into the values the carrier will show, in order.
    function automatic void build_period(input logic [1:0] md, input int t, input bit from_idle);
        int s;
        per_q.delete();
        m_top = t;
        if (md == 2'b01) begin
            for (int v = 0; v <= t; v++) push(v, 1'b1);
        end else if (md == 2'b10) begin
            s = (!from_idle && m_carrier == '0 && t != 0) ? 1 : 0;
            for (int v = s; v <= t; v++) push(v, v != t);
            for (int v = t - 1; v >= 0; v--) push(v, 1'b0);
        end else begin
            for (int v = t; v >= 0; v--) push(v, 1'b0);
        end
        per_q[0].ps = 1'b1;
    endfunction

    function automatic void show();
        ent_t e;
        e = per_q.pop_front();
        m_carrier = e.val;
        m_dir     = e.dir;
        m_ps      = e.ps;
        m_peak    = (int'(e.val) == m_top);
        m_valley  = (e.val == '0);
    endfunction

    function automatic void model_edge();
        m_step = 0; m_ps = 0; m_peak = 0; m_valley = 0;
        if (rst) begin
            m_busy = 0; m_carrier = '0; m_dir = 0; m_cnt = 0;
            per_q.delete();
        end else if (!m_busy) begin
            if (en) begin
                m_busy = 1; m_cnt = 0;
                build_period(mode, int'(top), 1'b1);
                show();
            end
        end else if (m_cnt == PRESCALE - 1) begin
            m_cnt = 0;
            if (per_q.size() == 0) begin
                if (!en) m_busy = 0;
                else begin
                    build_period(mode, int'(top), 1'b0);
                    show();
                    m_step = 1;
                end
            end else begin
                show();
                m_step = 1;
            end
        end else begin
            m_cnt++;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s t=%0t got %0d exp %0d", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        n_vec++;
        chk("carrier", 32'(carrier), 32'(m_carrier));
        chk("step", 32'(step), 32'(m_step));
        chk("period_start", 32'(period_start), 32'(m_ps));
        chk("peak", 32'(peak), 32'(m_peak));
        chk("valley", 32'(valley), 32'(m_valley));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic wait_carrier(input int val, input int maxc);
        int k;
        k = 0;
        while (int'(carrier) != val && k < maxc) begin
            tick();
            k++;
        end
        assert (k < maxc) else begin
            n_err++;
            $error("FAIL wait_carrier timeout got %0d exp %0d", carrier, val);
        end
    endtask

    initial begin
        m_carrier = '0; m_dir = 0; m_busy = 0; m_cnt = 0; m_top = 0;
        m_step = 0; m_ps = 0; m_peak = 0; m_valley = 0;

        // Reset held two clocks with en high, then start one clock after release.
        rst = 1; en = 1; mode = 2'b00; top = W'(5);
        tick(); tick();
        rst = 0;
        tick();
        chk("busy_after_release", 32'(busy), 32'(1));

        // Saw-down, top=5.
        repeat (40) tick();

        // Triangle, top=3.
        rst = 1; tick(); rst = 0; mode = 2'b10; top = W'(3);
        repeat (45) tick();

        // Graceful stop in saw-up, then restart.
        rst = 1; tick(); rst = 0; mode = 2'b01; top = W'(5);
        wait_carrier(2, 60);
        en = 0;
        repeat (15) tick();
        chk("stopped_hold", 32'(carrier), 32'(5));
        en = 1;
        repeat (8) tick();

        // Shadow reload of top, then of mode.
        rst = 1; tick(); rst = 0; mode = 2'b00; top = W'(5);
        tick();
        wait_carrier(3, 60);
        top = W'(2);
        repeat (30) tick();
        wait_carrier(1, 60);
        mode = 2'b10;
        repeat (30) tick();

        // Reserved mode behaves as saw-down.
        rst = 1; tick(); rst = 0; mode = 2'b11; top = W'(4);
        repeat (30) tick();

        // top=0 in triangle.
        rst = 1; tick(); rst = 0; mode = 2'b10; top = W'(0);
        repeat (12) tick();

        // Reset mid-run.
        rst = 1; tick(); rst = 0; mode = 2'b01; top = W'(6);
        wait_carrier(4, 60);
        rst = 1;
        tick();
        rst = 0;
        tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
                top = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 6));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
